ro_puf_ctrl: RTL and testbench
==============================

RO_PUF_CTRL -- requirements
Module: ro_puf_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  RESP_BITS, 16, response bits per run (1..64).
  WINDOW, 1024, Enable-high cycles per measurement (>=2).
  CLR_CYCLES, 2, counter-clear cycles per measurement (>=1).
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  clk  in  1  single clock.
  reset  in  1  asynchronous, active-low reset.
  start  in  1  run request, sampled in IDLE only.
  abort  in  1  cancel run in progress.
  base  in  4  first Cha0 index, latched at start.
  offset  in  4  Cha1 distance from Cha0, latched at start.
  Response  in  1  comparator bit from counter group, asynchronous to clk.
  Cha0  out  4  RO select A to counter group.
  Cha1  out  4  RO select B to counter group.
  Enable  out  1  RO array enable.
  puf_reset  out  1  active-high counter clear to counter group.
  busy  out  1  high in any state other than IDLE.
  resp_valid  out  1  one-cycle pulse, resp_data complete.
  resp_data  out  RESP_BITS  collected response, bit k = pair k.

Function
REQ-003 FSM states SHALL be IDLE, CLEAR, RUN, SAMPLE, DONE.
REQ-004 IDLE: start=1 at an edge -> CLEAR next cycle; base, offset latched; index k=0; resp_data cleared to 0.
REQ-005 CLEAR: puf_reset=1, Enable=0, exactly CLR_CYCLES cycles, then RUN.
REQ-006 RUN: puf_reset=0, Enable=1, exactly WINDOW cycles, then SAMPLE.
REQ-007 SAMPLE: Enable=0 for 3 cycles; Response passes through a 2-flop synchronizer; synchronized value captured into resp_data[k] on the last SAMPLE cycle.
REQ-008 After capture: k=RESP_BITS-1 -> DONE; else k increments -> CLEAR.
REQ-009 DONE: resp_valid=1 for exactly one cycle, then IDLE; resp_data held until next accepted start.
REQ-010 Cha0 SHALL be (base+k) mod 16, Cha1 SHALL be (base+k+eff_off) mod 16, 4-bit wrap; eff_off = offset, except offset=0 -> eff_off=1 (never same RO).
REQ-011 Cha0/Cha1 SHALL be stable from first CLEAR cycle to last SAMPLE cycle of each bit; 0 in IDLE.
REQ-012 Latency, macro off: resp_valid SHALL assert RESP_BITS*(CLR_CYCLES+WINDOW+3)+1 cycles after the edge that samples start.
REQ-013 start while busy SHALL be ignored.
REQ-014 abort=1 in CLEAR/RUN/SAMPLE SHALL force IDLE next cycle, Enable=0, puf_reset=0, no resp_valid, resp_data undefined-but-stable (keeps partial bits); abort in IDLE/DONE ignored; abort and start together in IDLE -> stay IDLE.

Reset
REQ-015 reset=0 SHALL asynchronously force IDLE, k=0, Cha0=Cha1=0, Enable=0, puf_reset=1, busy=0, resp_valid=0, resp_data=0, synchronizer flops=0.
REQ-016 puf_reset SHALL deassert on first clk edge after reset release; reset mid-run discards the run.

Configuration
REQ-017 Macro RO_PUF_MAJORITY_EN defined: each bit SHALL be measured 3 times (CLEAR/RUN/SAMPLE repeated, same Cha0/Cha1), resp_data[k] = majority of the 3 captures; latency = RESP_BITS*3*(CLR_CYCLES+WINDOW+3)+1.
REQ-018 Macro undefined: single measurement per bit, no vote logic or sub-counter present.

Verification (RESP_BITS=4, WINDOW=8, CLR_CYCLES=2)
REQ-019 base=3, offset=5, Response model = pattern 1,0,1,1 per pair -> resp_data=4'b1101, resp_valid pulse 53 cycles after start; Cha0/Cha1 sequence (3,8),(4,9),(5,10),(6,11).
REQ-020 base=14, offset=0 -> pairs (14,15),(15,0),(0,1),(1,2); wrap and eff_off=1 confirmed.
REQ-021 Enable high exactly 8 cycles per bit, puf_reset high exactly 2 cycles before each window, never both high together.
REQ-022 abort asserted in RUN of bit 2 -> busy=0 next cycle, Enable=0, no resp_valid; following start completes normally.
REQ-023 start pulsed at cycle 10 of a run -> ignored, run completes at cycle 53 unchanged.
REQ-024 RO_PUF_MAJORITY_EN defined, Response captures 1,0,1 for pair 0 and 0,0,1 for pair 1 -> resp_data[0]=1, resp_data[1]=0, resp_valid at cycle 157.

Source files
------------

// File: rtl/ro_puf_ctrl.sv
// ro_puf_ctrl: ring-oscillator PUF sequencer that clears, enables and samples one RO pair per response bit.
// Define RO_PUF_MAJORITY_EN to measure every pair three times and keep the majority vote.
module ro_puf_ctrl #(
  parameter int RESP_BITS  = 16,
  parameter int WINDOW     = 1024,
  parameter int CLR_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [3:0]           base,
  input  logic [3:0]           offset,
  input  logic                 Response,
  output logic [3:0]           Cha0,
  output logic [3:0]           Cha1,
  output logic                 Enable,
  output logic                 puf_reset,
  output logic                 busy,
  output logic                 resp_valid,
  output logic [RESP_BITS-1:0] resp_data
);
  localparam int CW = $clog2(WINDOW + CLR_CYCLES + 4);
  localparam int KW = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
  typedef enum logic [2:0] {IDLE, CLEAR, RUN, SAMPLE, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [KW-1:0] k_q, k_d;
  logic [3:0] base_q, base_d, off_q, off_d, cha0_q, cha0_d, cha1_q, cha1_d;
  logic en_q, en_d, clr_q, clr_d, busy_q, busy_d, valid_q, valid_d;
  logic [RESP_BITS-1:0] data_q, data_d;
  logic sync1_q, sync2_q, bit_v, last_meas;
`ifdef RO_PUF_MAJORITY_EN
  logic [1:0] rep_q, rep_d, votes_q, votes_d;
`endif
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    base_d  = base_q;
    off_d   = off_q;
    cha0_d  = cha0_q;
    cha1_d  = cha1_q;
    data_d  = data_q;
`ifdef RO_PUF_MAJORITY_EN
    rep_d     = rep_q;
    votes_d   = votes_q;
    last_meas = rep_q == 2'd2;
    bit_v     = (votes_q + {1'b0, sync2_q}) >= 2'd2;
`else
    last_meas = 1'b1;
    bit_v     = sync2_q;
`endif
    case (state_q)
      IDLE: if (start && !abort) begin
        state_d = CLEAR;
        cnt_d   = CW'(CLR_CYCLES - 1);
        k_d     = '0;
        data_d  = '0;
        base_d  = base;
        off_d   = (offset == 4'd0) ? 4'd1 : offset;
        cha0_d  = base;
        cha1_d  = base + ((offset == 4'd0) ? 4'd1 : offset);
      end
      CLEAR: begin
        state_d = (cnt_q == '0) ? RUN : CLEAR;
        cnt_d   = (cnt_q == '0) ? CW'(WINDOW - 1) : cnt_q - CW'(1);
      end
      RUN: begin
        state_d = (cnt_q == '0) ? SAMPLE : RUN;
        cnt_d   = (cnt_q == '0) ? CW'(2) : cnt_q - CW'(1);
      end
      SAMPLE: if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
      else begin
        state_d = CLEAR;
        cnt_d   = CW'(CLR_CYCLES - 1);
`ifdef RO_PUF_MAJORITY_EN
        rep_d   = last_meas ? 2'd0 : rep_q + 2'd1;
        votes_d = last_meas ? 2'd0 : votes_q + {1'b0, sync2_q};
`endif
        if (last_meas) begin
          data_d[k_q] = bit_v;
          if (k_q == KW'(RESP_BITS - 1)) state_d = DONE;
          else begin
            k_d    = k_q + KW'(1);
            cha0_d = base_q + 4'(k_q) + 4'd1;
            cha1_d = cha0_d + off_q;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort && (state_q inside {CLEAR, RUN, SAMPLE})) begin
      state_d = IDLE;
`ifdef RO_PUF_MAJORITY_EN
      rep_d   = 2'd0;
      votes_d = 2'd0;
`endif
    end
    if (state_d == IDLE || state_d == DONE) begin
      cha0_d = 4'd0;
      cha1_d = 4'd0;
    end
    en_d    = state_d == RUN;
    clr_d   = state_d == CLEAR;
    busy_d  = state_d != IDLE;
    valid_d = state_d == DONE;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      k_q     <= '0;
      base_q  <= 4'd0;
      off_q   <= 4'd1;
      cha0_q  <= 4'd0;
      cha1_q  <= 4'd0;
      en_q    <= 1'b0;
      clr_q   <= 1'b1;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
`ifdef RO_PUF_MAJORITY_EN
      rep_q   <= 2'd0;
      votes_q <= 2'd0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      base_q  <= base_d;
      off_q   <= off_d;
      cha0_q  <= cha0_d;
      cha1_q  <= cha1_d;
      en_q    <= en_d;
      clr_q   <= clr_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      sync1_q <= Response;
      sync2_q <= sync1_q;
`ifdef RO_PUF_MAJORITY_EN
      rep_q   <= rep_d;
      votes_q <= votes_d;
`endif
    end
  end
  assign Cha0       = cha0_q;
  assign Cha1       = cha1_q;
  assign Enable     = en_q;
  assign puf_reset  = clr_q;
  assign busy       = busy_q;
  assign resp_valid = valid_q;
  assign resp_data  = data_q;
endmodule

// File: tb/tb_ro_puf_ctrl.sv
// tb_ro_puf_ctrl: directed vector bench for ro_puf_ctrl with RESP_BITS=4, WINDOW=8, CLR_CYCLES=2.
module tb_ro_puf_ctrl;
  localparam int RB = 4, WIN = 8, CLR = 2;
`ifdef RO_PUF_MAJORITY_EN
  localparam int REPS = 3;
`else
  localparam int REPS = 1;
`endif
  localparam int LAT = RB * REPS * (CLR + WIN + 3) + 1;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, abort = 1'b0;
  logic [3:0] base = 4'd0, offset = 4'd0, Cha0, Cha1;
  logic Response, Enable, puf_reset, busy, resp_valid;
  logic [RB-1:0] resp_data;
  logic [63:0] meas_pat = '0;
  int meas_idx = -1;
  int n_cmp = 0, n_err = 0;
  typedef struct {
    logic [3:0]  b, o, pat, exp_d;
    logic [31:0] pairs;
  } vec_t;
  vec_t vt[4];
  ro_puf_ctrl #(.RESP_BITS(RB), .WINDOW(WIN), .CLR_CYCLES(CLR)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .base(base), .offset(offset),
    .Response(Response), .Cha0(Cha0), .Cha1(Cha1), .Enable(Enable), .puf_reset(puf_reset),
    .busy(busy), .resp_valid(resp_valid), .resp_data(resp_data)
  );
  always #5 clk = ~clk;
  // Each rising puf_reset starts a new measurement; Response follows its scripted bit.
  always @(posedge puf_reset) meas_idx = meas_idx + 1;
  assign Response = (meas_idx >= 0 && meas_idx < 64) ? meas_pat[meas_idx[5:0]] : 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] expand(input logic [3:0] p);
    logic [63:0] r = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < REPS; j++) r[i*REPS+j] = p[i];
    return r;
  endfunction

  task automatic do_run(input logic [3:0] b, input logic [3:0] o, input logic [63:0] mp,
                        input logic [3:0] exp_d, input logic [31:0] exp_pairs, input int poke,
                        input string nm);
    int cyc, en_n, pr_n, both_n, unst, meas;
    logic [31:0] got;
    logic prev_pr, seen;
    logic [3:0] pc0, pc1;
    meas_pat = mp;
    meas_idx = -1;
    @(negedge clk);
    base = b; offset = o; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1; en_n = 0; pr_n = 0; both_n = 0; unst = 0; meas = 0;
    got = '0; prev_pr = 1'b0; seen = 1'b0; pc0 = 4'd0; pc1 = 4'd0;
    while (cyc <= LAT + 20) begin
      if (resp_valid) begin
        seen = 1'b1;
        break;
      end
      if (Enable) en_n++;
      if (puf_reset) pr_n++;
      if (Enable && puf_reset) both_n++;
      if (puf_reset && !prev_pr) begin
        if (meas % REPS == 0) got = {got[23:0], Cha0, Cha1};
        meas++;
      end else if (busy && {Cha0, Cha1} != {pc0, pc1}) unst++;
      prev_pr = puf_reset; pc0 = Cha0; pc1 = Cha1;
      if (cyc == poke) begin
        start = 1'b1; base = 4'd9; offset = 4'd2;
      end else start = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    chk({nm, " valid_seen"}, 64'(seen), 1);
    chk({nm, " latency"}, 64'(cyc), 64'(LAT));
    chk({nm, " resp_data"}, 64'(resp_data), 64'(exp_d));
    chk({nm, " pairs"}, 64'(got), 64'(exp_pairs));
    chk({nm, " enable_cycles"}, 64'(en_n), 64'(RB * REPS * WIN));
    chk({nm, " clear_cycles"}, 64'(pr_n), 64'(RB * REPS * CLR));
    chk({nm, " overlap"}, 64'(both_n), 0);
    chk({nm, " cha_stable"}, 64'(unst), 0);
    @(posedge clk); #1;
    chk({nm, " valid_width"}, 64'(resp_valid), 0);
    chk({nm, " busy_after"}, 64'(busy), 0);
    chk({nm, " cha_idle"}, 64'({Cha0, Cha1}), 0);
    chk({nm, " data_held"}, 64'(resp_data), 64'(exp_d));
  endtask

  initial begin
    int n;
    logic found;
    vt[0] = '{4'd3,  4'd5,  4'b1101, 4'b1101, 32'h38495a6b};
    vt[1] = '{4'd14, 4'd0,  4'b0110, 4'b0110, 32'heff00112};
    vt[2] = '{4'd10, 4'd15, 4'b0000, 4'b0000, 32'ha9bacbdc};
    vt[3] = '{4'd0,  4'd8,  4'b1111, 4'b1111, 32'h08192a3b};
    #3 reset = 1'b0;
    #1;
    chk("rst cha", 64'({Cha0, Cha1}), 0);
    chk("rst enable", 64'(Enable), 0);
    chk("rst puf_reset", 64'(puf_reset), 1);
    chk("rst busy", 64'(busy), 0);
    chk("rst valid", 64'(resp_valid), 0);
    chk("rst data", 64'(resp_data), 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("puf_reset release", 64'(puf_reset), 0);
    for (int i = 0; i < 4; i++)
      do_run(vt[i].b, vt[i].o, expand(vt[i].pat), vt[i].exp_d, vt[i].pairs, -1, $sformatf("vec%0d", i));
    do_run(4'd3, 4'd5, expand(4'b1101), 4'b1101, 32'h38495a6b, 10, "busy_start");
    // abort during the enable window of the third pair
    meas_pat = expand(4'b1101);
    meas_idx = -1;
    @(negedge clk);
    base = 4'd3; offset = 4'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      if (Cha0 == 4'd5 && Enable) found = 1'b1;
      else begin @(posedge clk); #1; end
    end
    chk("abort reach_run2", 64'(found), 1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort busy", 64'(busy), 0);
    chk("abort enable", 64'(Enable), 0);
    chk("abort puf_reset", 64'(puf_reset), 0);
    chk("abort cha", 64'({Cha0, Cha1}), 0);
    n = 0;
    repeat (LAT) begin
      @(posedge clk); #1;
      if (resp_valid) n++;
    end
    chk("abort no_valid", 64'(n), 0);
    chk("abort partial", 64'(resp_data), 64'(4'b0001));
    do_run(4'd3, 4'd5, expand(4'b1101), 4'b1101, 32'h38495a6b, -1, "after_abort");
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    chk("start_abort idle", 64'(busy), 0);
    // asynchronous reset in the middle of a run
    meas_idx = -1;
    @(negedge clk);
    base = 4'd2; offset = 4'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("midrst busy", 64'(busy), 0);
    chk("midrst puf_reset", 64'(puf_reset), 1);
    chk("midrst enable", 64'(Enable), 0);
    chk("midrst data", 64'(resp_data), 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midrst discarded", 64'(busy), 0);
    chk("midrst puf_release", 64'(puf_reset), 0);
`ifdef RO_PUF_MAJORITY_EN
    do_run(4'd0, 4'd1, 64'b010011100101, 4'b0101, 32'h01122334, -1, "majority");
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
